fifo_uart_tx: RTL

- Downstream drain stage for the 4-bit FIFO on the Zybo Z7.
- Whenever the FIFO reports non-empty, it pops one entry and converts the nibble to an ASCII hex character ('0'-'9', 'A'-'F').
- It then transmits that character as a UART 8N1 frame on tx.
- It drives the FIFO read strobe and data/status select, so the FIFO contents can be observed on a serial terminal.

---
 rtl/fifo_uart_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops nibbles from a FIFO and sends each one as an ASCII hex character over UART 8N1.
// Optional macro FIFO_TX_CRLF_EN appends CR and LF frames after every hex character.
module fifo_uart_tx #(
  parameter int WIDTH    = 4,
  parameter int CLK_FREQ = 125000000,
  parameter int BAUD     = 115200,
  parameter int RD_LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             fifo_status,
  output logic             tx,
  output logic             busy,
  output logic [7:0]       char_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int WAIT_W       = $clog2(RD_LAT + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_START = 3'd4,
    S_DATA  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = 8'h37 + {4'h0, n};
  endfunction

  state_t            state_r, state_s;
  logic [BAUD_W-1:0] baud_r, baud_s;
  logic [2:0]        bit_r, bit_s;
  logic [7:0]        shift_r, shift_s;
  logic [WAIT_W-1:0] wait_r, wait_s;
  logic [1:0]        gap_r, gap_s;
  logic [7:0]        char_cnt_r, char_cnt_s;
  logic              fifo_rd_r, fifo_rd_s;
  logic              tx_r, tx_s;
  logic              busy_r, busy_s;
  logic              status_r;
  logic [3:0]        nib_s;
  logic              baud_end_s;
  logic              gap_done_s;
`ifdef FIFO_TX_CRLF_EN
  logic [1:0]        crlf_r, crlf_s;
`endif

  assign nib_s      = 4'(fifo_data);
  assign baud_end_s = (baud_r == BAUD_LAST);
  // Two full idle cycles after a frame let the registered Empty flag catch up with the pop.
  assign gap_done_s = (gap_r == 2'd2);

  // Next-state and datapath update for the drain/transmit sequence.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    wait_s     = wait_r;
    gap_s      = 2'd0;
    char_cnt_s = char_cnt_r;
`ifdef FIFO_TX_CRLF_EN
    crlf_s     = crlf_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (gap_r != 2'd2) gap_s = gap_r + 2'd1;
        else               gap_s = gap_r;
        if (en && !fifo_empty && gap_done_s) state_s = S_REQ;
        else                                 state_s = S_IDLE;
      end
      S_REQ: begin
        wait_s  = WAIT_LOAD;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (wait_r == WAIT_ZERO) state_s = S_LOAD;
        else                     wait_s  = wait_r - WAIT_ONE;
      end
      S_LOAD: begin
        shift_s = hex_ascii(nib_s);
        baud_s  = BAUD_ZERO;
        state_s = S_START;
`ifdef FIFO_TX_CRLF_EN
        crlf_s  = 2'd0;
`endif
      end
      S_START: begin
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          state_s = S_DATA;
        end else begin
          baud_s  = baud_r + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_s = BAUD_ZERO;
          if (bit_r == 3'd7) begin
            state_s = S_STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_s = BAUD_ZERO;
`ifdef FIFO_TX_CRLF_EN
          case (crlf_r)
            2'd0: begin
              char_cnt_s = char_cnt_r + 8'd1;
              shift_s    = 8'h0D;
              crlf_s     = 2'd1;
              state_s    = S_START;
            end
            2'd1: begin
              shift_s = 8'h0A;
              crlf_s  = 2'd2;
              state_s = S_START;
            end
            default: begin
              crlf_s  = 2'd0;
              state_s = S_IDLE;
            end
          endcase
`else
          char_cnt_s = char_cnt_r + 8'd1;
          state_s    = S_IDLE;
`endif
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so that the registered copies line up with the state.
  always_comb begin
    fifo_rd_s = (state_s == S_REQ);
    busy_s    = (state_s != S_IDLE);
    case (state_s)
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      baud_r     <= BAUD_ZERO;
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      wait_r     <= WAIT_ZERO;
      gap_r      <= 2'd0;
      char_cnt_r <= 8'd0;
      fifo_rd_r  <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      status_r   <= 1'b1;
`ifdef FIFO_TX_CRLF_EN
      crlf_r     <= 2'd0;
`endif
    end else begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      wait_r     <= wait_s;
      gap_r      <= gap_s;
      char_cnt_r <= char_cnt_s;
      fifo_rd_r  <= fifo_rd_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      status_r   <= 1'b1;
`ifdef FIFO_TX_CRLF_EN
      crlf_r     <= crlf_s;
`endif
    end
  end

  assign fifo_rd     = fifo_rd_r;
  assign fifo_status = status_r;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign char_cnt    = char_cnt_r;

endmodule
